// File: rtl/ahb_protected_sram.sv
// ============================================================================
//  Module   : ahb_protected_sram
//  Purpose  : AHB-Lite subordinate wrapping a single-ported word SRAM. It
//             checks the address-phase parity and the write-data SEC-DED
//             checksum, stores a checksum with every word and returns it with
//             read data. Integrity, range, size and alignment violations
//             produce the two-cycle AHB ERROR response.
//  Option   : AHB_RESP_INTEGRITY_EN enables the parity/checksum checks and
//             the s_hrchecksum_o output. When undefined, only range, size and
//             alignment errors are reported and s_hrchecksum_o is 0.
//  Ports    : s_clk_i/s_resetn_i   clock, async active-low reset
//             s_h*_i               AHB-Lite address/data phase inputs
//             s_hparity_i          {^htrans, ^{hwrite,hsize}, ^haddr bytes 3..0}
//             s_hwchecksum_i       (39,32) SEC-DED checksum of s_hwdata_i
//             s_hrdata_o/s_hrchecksum_o  read data and its stored checksum
//             s_hready_o/s_hresp_o transfer done / OKAY(0) ERROR(1)
//             s_errcnt_o           saturating count of ERROR responses
//  Revision : 1.0 initial release
// ============================================================================
`default_nettype none

module ahb_protected_sram #(
   parameter int MEM_ADDR_W  = 10,
   parameter int WAIT_STATES = 0,
   parameter int ERRCNT_W    = 8
) (
   input  logic                s_clk_i,
   input  logic                s_resetn_i,
   input  logic                s_hsel_i,
   input  logic [31:0]         s_haddr_i,
   input  logic [1:0]          s_htrans_i,
   input  logic                s_hwrite_i,
   input  logic [2:0]          s_hsize_i,
   input  logic [5:0]          s_hparity_i,
   input  logic [31:0]         s_hwdata_i,
   input  logic [6:0]          s_hwchecksum_i,
   input  logic                s_hready_i,
   output logic [31:0]         s_hrdata_o,
   output logic [6:0]          s_hrchecksum_o,
   output logic                s_hready_o,
   output logic                s_hresp_o,
   output logic [ERRCNT_W-1:0] s_errcnt_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ERR1 = 2'd2;
   localparam logic [1:0] ST_ERR2 = 2'd3;
   localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   // Extended Hamming (39,32): data occupy codeword positions 1..38 that are
   // not powers of two; check bit k is the parity of positions with bit k set,
   // check bit 6 is the overall parity of data and check bits.
   function automatic logic [6:0] secded_enc(input logic [31:0] d);
      logic [6:0]  c;
      logic [5:0]  pos;
      logic [31:0] dd;
      c  = '0;
      dd = d;
      for (int p = 1; p < 39; p++) begin
         pos = 6'(p);
         if ((pos & (pos - 6'd1)) != 6'd0) begin
            if (dd[0]) c[5:0] = c[5:0] ^ pos;
            dd = dd >> 1;
         end
      end
      c[6] = (^d) ^ (^c[5:0]);
      return c;
   endfunction

   logic [1:0]            state, state_nxt;
   logic [2:0]            wait_cnt;
   logic                  dp_pend;
   logic [MEM_ADDR_W+1:0] addr_q;
   logic                  write_q;
   logic [1:0]            size_q;
   logic [ERRCNT_W-1:0]   errcnt_q;
   logic [31:0]           rdata_hold;
   logic [38:0]           mem [0:(1 << MEM_ADDR_W)-1];

   logic                  accept, take, addr_err, par_err, wchk_err;
   logic                  completing, wr_bad, wr_commit, rd_complete;
   logic [1:0]            take_state;
   logic [MEM_ADDR_W-1:0] idx;
   logic [38:0]           mem_word;
   logic [3:0]            lane_mask;
   logic [31:0]           merged;

   assign accept = s_hsel_i & s_htrans_i[1] & s_hready_i;

`ifdef AHB_RESP_INTEGRITY_EN
   logic [6:0] rchk_hold;
   assign par_err  = s_hparity_i != {^s_htrans_i, ^{s_hwrite_i, s_hsize_i},
                                     ^s_haddr_i[31:24], ^s_haddr_i[23:16],
                                     ^s_haddr_i[15:8],  ^s_haddr_i[7:0]};
   assign wchk_err = secded_enc(s_hwdata_i) != s_hwchecksum_i;
`else
   logic unused_ok;
   assign par_err   = 1'b0;
   assign wchk_err  = 1'b0;
   assign unused_ok = ^{s_hparity_i, s_hwchecksum_i, s_htrans_i[0], mem_word[38:32]};
`endif

   assign addr_err = par_err
                   | (|s_haddr_i[31:MEM_ADDR_W+2])
                   | (s_hsize_i > 3'b010)
                   | ((s_hsize_i == 3'b001) & s_haddr_i[0])
                   | ((s_hsize_i == 3'b010) & (|s_haddr_i[1:0]));

   // The data phase completes in IDLE while a transfer is pending; a bad
   // write checksum turns that cycle into the first ERROR cycle.
   assign completing  = (state == ST_IDLE) & dp_pend;
   assign wr_bad      = completing & write_q & wchk_err;
   assign wr_commit   = completing & write_q & ~wchk_err;
   assign rd_complete = completing & ~write_q;
   assign take        = accept & (((state == ST_IDLE) & ~wr_bad) | (state == ST_ERR2));
   assign take_state  = addr_err ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_IDLE);

   assign idx      = addr_q[MEM_ADDR_W+1:2];
   assign mem_word = mem[idx];

   always_comb begin
      lane_mask = 4'b1111;
      case (size_q)
         2'b00:   lane_mask = 4'b0001 << addr_q[1:0];
         2'b01:   lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
         default: lane_mask = 4'b1111;
      endcase
      merged = mem_word[31:0];
      for (int i = 0; i < 4; i++) begin
         if (lane_mask[i]) merged[8*i +: 8] = s_hwdata_i[8*i +: 8];
      end
   end

   // State register and data-phase bookkeeping
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         state      <= ST_IDLE;
         wait_cnt   <= 3'd0;
         dp_pend    <= 1'b0;
         addr_q     <= '0;
         write_q    <= 1'b0;
         size_q     <= 2'b00;
         errcnt_q   <= '0;
         rdata_hold <= 32'd0;
`ifdef AHB_RESP_INTEGRITY_EN
         rchk_hold  <= 7'd0;
`endif
      end else begin
         state <= state_nxt;
         if (take) begin
            dp_pend  <= ~addr_err;
            wait_cnt <= WAIT_LOAD;
            addr_q   <= s_haddr_i[MEM_ADDR_W+1:0];
            write_q  <= s_hwrite_i;
            size_q   <= s_hsize_i[1:0];
         end else begin
            if (state != ST_WAIT) dp_pend <= 1'b0;
            if ((state == ST_WAIT) && (wait_cnt != 3'd0)) wait_cnt <= wait_cnt - 3'd1;
         end
         if ((state_nxt == ST_ERR2) && (errcnt_q != {ERRCNT_W{1'b1}})) begin
            errcnt_q <= errcnt_q + 1'b1;
         end
         if (rd_complete) begin
            rdata_hold <= mem_word[31:0];
`ifdef AHB_RESP_INTEGRITY_EN
            rchk_hold  <= mem_word[38:32];
`endif
         end
      end
   end

   // Memory array is not reset; dp_pend is, so reset aborts any commit.
   always_ff @(posedge s_clk_i) begin
      if (wr_commit) mem[idx] <= {secded_enc(merged), merged};
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (wr_bad)      state_nxt = ST_ERR2;
            else if (accept) state_nxt = take_state;
            else             state_nxt = ST_IDLE;
         end
         ST_WAIT: state_nxt = (wait_cnt == 3'd0) ? ST_IDLE : ST_WAIT;
         ST_ERR1: state_nxt = ST_ERR2;
         ST_ERR2: state_nxt = accept ? take_state : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      s_hready_o = 1'b1;
      s_hresp_o  = 1'b0;
      case (state)
         ST_IDLE: if (wr_bad) begin
            s_hready_o = 1'b0;
            s_hresp_o  = 1'b1;
         end
         ST_WAIT: s_hready_o = 1'b0;
         ST_ERR1: begin
            s_hready_o = 1'b0;
            s_hresp_o  = 1'b1;
         end
         ST_ERR2: s_hresp_o = 1'b1;
         default: ;
      endcase
   end

   assign s_hrdata_o = rd_complete ? mem_word[31:0] : rdata_hold;
`ifdef AHB_RESP_INTEGRITY_EN
   assign s_hrchecksum_o = rd_complete ? mem_word[38:32] : rchk_hold;
`else
   assign s_hrchecksum_o = 7'd0;
`endif
   assign s_errcnt_o = errcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_protected_sram.sv
// ============================================================================
//  Module   : tb_ahb_protected_sram
//  Purpose  : Directed bench for ahb_protected_sram. dut0 has no wait states;
//             dut3 has three wait states and a 2-bit error counter. Both share
//             the request inputs, each loops its own HREADY back.
//  Revision : 1.0 initial release
// ============================================================================
`default_nettype none

module tb_ahb_protected_sram;

`ifdef AHB_RESP_INTEGRITY_EN
   localparam bit INTEG = 1'b1;
`else
   localparam bit INTEG = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hsel = 1'b0;
   logic [31:0] haddr = '0;
   logic [1:0]  htrans = 2'b00;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'b000;
   logic [5:0]  hparity = '0;
   logic [31:0] hwdata = '0;
   logic [6:0]  hwchk = '0;

   logic [31:0] rdata0, rdata3;
   logic [6:0]  rchk0, rchk3;
   logic        rdy0, rdy3, resp0, resp3;
   logic [7:0]  errcnt0;
   logic [1:0]  errcnt3;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ahb_protected_sram #(.MEM_ADDR_W(10), .WAIT_STATES(0), .ERRCNT_W(8)) dut0 (
      .s_clk_i(clk), .s_resetn_i(rst_n), .s_hsel_i(hsel), .s_haddr_i(haddr),
      .s_htrans_i(htrans), .s_hwrite_i(hwrite), .s_hsize_i(hsize),
      .s_hparity_i(hparity), .s_hwdata_i(hwdata), .s_hwchecksum_i(hwchk),
      .s_hready_i(rdy0), .s_hrdata_o(rdata0), .s_hrchecksum_o(rchk0),
      .s_hready_o(rdy0), .s_hresp_o(resp0), .s_errcnt_o(errcnt0));

   ahb_protected_sram #(.MEM_ADDR_W(10), .WAIT_STATES(3), .ERRCNT_W(2)) dut3 (
      .s_clk_i(clk), .s_resetn_i(rst_n), .s_hsel_i(hsel), .s_haddr_i(haddr),
      .s_htrans_i(htrans), .s_hwrite_i(hwrite), .s_hsize_i(hsize),
      .s_hparity_i(hparity), .s_hwdata_i(hwdata), .s_hwchecksum_i(hwchk),
      .s_hready_i(rdy3), .s_hrdata_o(rdata3), .s_hrchecksum_o(rchk3),
      .s_hready_o(rdy3), .s_hresp_o(resp3), .s_errcnt_o(errcnt3));

   // Reference encoder: build the 38-bit Hamming codeword, then take the
   // parity of every position class.
   function automatic logic [6:0] ref_enc(input logic [31:0] d);
      logic [38:0] cw;
      logic [6:0]  c;
      int j;
      cw = '0;
      j  = 0;
      for (int p = 1; p <= 38; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p] = d[j];
            j++;
         end
      end
      c = '0;
      for (int k = 0; k < 6; k++) begin
         for (int p = 1; p <= 38; p++) begin
            if (((p >> k) & 1) == 1) c[k] = c[k] ^ cw[p];
         end
      end
      c[6] = (^cw) ^ (^c[5:0]);
      return c;
   endfunction

   function automatic logic [5:0] ref_par(input logic [31:0] a, input logic w,
                                          input logic [2:0] s, input logic [1:0] t);
      return {^t, ^{w, s}, ^a[31:24], ^a[23:16], ^a[15:8], ^a[7:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Non-pipelined transfer: address phase, then data phase sampled on each
   // falling edge until the selected DUT reports ready.
   task automatic xfer(input bit on3, input bit wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit bad_par, input bit bad_chk,
                       output int lows, output bit resp_low, output bit resp_end,
                       output logic [31:0] rd, output logic [6:0] rc);
      bit done;
      hsel    = 1'b1;
      htrans  = 2'b10;
      hwrite  = wr;
      hsize   = sz;
      haddr   = a;
      hparity = ref_par(a, wr, sz, 2'b10) ^ (bad_par ? 6'h01 : 6'h00);
      tick();
      hsel    = 1'b0;
      htrans  = 2'b00;
      hwrite  = 1'b0;
      hsize   = 3'b000;
      haddr   = '0;
      hparity = '0;
      hwdata  = wd;
      hwchk   = ref_enc(wd) ^ (bad_chk ? 7'h01 : 7'h00);
      lows = 0; resp_low = 1'b0; resp_end = 1'b0; rd = '0; rc = '0; done = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (on3 ? rdy3 : rdy0) begin
            resp_end = on3 ? resp3 : resp0;
            rd       = on3 ? rdata3 : rdata0;
            rc       = on3 ? rchk3 : rchk0;
            done     = 1'b1;
         end else begin
            lows++;
            resp_low = on3 ? resp3 : resp0;
            if (lows > 16) begin
               n_cmp++;
               n_fail++;
               $display("FAIL timeout: hready stuck low at %h", a);
               done = 1'b1;
            end
         end
      end
      tick();
   endtask

   typedef struct {
      bit          wr;
      logic [2:0]  sz;
      logic [31:0] a;
      logic [31:0] wd;
      bit          bp;
      bit          bc;
      bit          err;
      bit          chk_rd;
      logic [31:0] rd;
   } vec_t;

   function automatic vec_t mk(bit wr, logic [2:0] sz, logic [31:0] a, logic [31:0] wd,
                               bit bp, bit bc, bit err, bit chk_rd, logic [31:0] rd);
      vec_t v;
      v.wr = wr; v.sz = sz; v.a = a; v.wd = wd; v.bp = bp; v.bc = bc;
      v.err = err; v.chk_rd = chk_rd; v.rd = rd;
      return v;
   endfunction

   vec_t vecs[19];

   initial begin
      int          lows;
      bit          rl, re;
      logic [31:0] rd;
      logic [6:0]  rc;
      int          exp_err;
      string       nm;

      vecs[0]  = mk(1, 3'b010, 32'h10,   32'hDEADBEEF, 0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 3'b010, 32'h10,   32'h0,        0, 0, 0, 1, 32'hDEADBEEF);
      vecs[2]  = mk(1, 3'b010, 32'h14,   32'h00000000, 0, 0, 0, 0, 0);
      vecs[3]  = mk(1, 3'b000, 32'h15,   32'h0000A500, 0, 0, 0, 0, 0);
      vecs[4]  = mk(0, 3'b010, 32'h14,   32'h0,        0, 0, 0, 1, 32'h0000A500);
      vecs[5]  = mk(1, 3'b010, 32'h10,   32'h12345678, 1, 0, INTEG, 0, 0);
      vecs[6]  = mk(0, 3'b010, 32'h10,   32'h0,        0, 0, 0, 1,
                    INTEG ? 32'hDEADBEEF : 32'h12345678);
      vecs[7]  = mk(1, 3'b010, 32'h18,   32'h11111111, 0, 0, 0, 0, 0);
      vecs[8]  = mk(1, 3'b010, 32'h18,   32'hCAFEF00D, 0, 1, INTEG, 0, 0);
      vecs[9]  = mk(0, 3'b010, 32'h18,   32'h0,        0, 0, 0, 1,
                    INTEG ? 32'h11111111 : 32'hCAFEF00D);
      vecs[10] = mk(1, 3'b001, 32'h1A,   32'hBEEF0000, 0, 0, 0, 0, 0);
      vecs[11] = mk(0, 3'b010, 32'h18,   32'h0,        0, 0, 0, 1,
                    INTEG ? 32'hBEEF1111 : 32'hBEEFF00D);
      vecs[12] = mk(1, 3'b010, 32'h12,   32'h77777777, 0, 0, 1, 0, 0);
      vecs[13] = mk(0, 3'b010, 32'h1000, 32'h0,        0, 0, 1, 0, 0);
      vecs[14] = mk(0, 3'b011, 32'h20,   32'h0,        0, 0, 1, 0, 0);
      vecs[15] = mk(0, 3'b001, 32'h21,   32'h0,        0, 0, 1, 0, 0);
      vecs[16] = mk(0, 3'b000, 32'h13,   32'h0,        0, 0, 0, 1,
                    INTEG ? 32'hDEADBEEF : 32'h12345678);
      vecs[17] = mk(1, 3'b010, 32'hFFC,  32'hAAAA5555, 0, 0, 0, 0, 0);
      vecs[18] = mk(0, 3'b010, 32'hFFC,  32'h0,        0, 0, 0, 1, 32'hAAAA5555);

      // Reset values
      #3;
      check("rst_hready0", rdy0, 1);   check("rst_hresp0", resp0, 0);
      check("rst_rdata0", rdata0, 0);  check("rst_rchk0", rchk0, 0);
      check("rst_errcnt0", errcnt0, 0);
      check("rst_hready3", rdy3, 1);   check("rst_errcnt3", errcnt3, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Table-driven transfers on the zero-wait instance
      exp_err = 0;
      for (int i = 0; i < 19; i++) begin
         xfer(0, vecs[i].wr, vecs[i].sz, vecs[i].a, vecs[i].wd, vecs[i].bp, vecs[i].bc,
              lows, rl, re, rd, rc);
         nm = $sformatf("v%0d", i);
         if (vecs[i].err) exp_err++;
         check({nm, "_resp"}, re, vecs[i].err);
         check({nm, "_lows"}, lows, vecs[i].err ? 1 : 0);
         if (vecs[i].err) check({nm, "_resp_low"}, rl, 1);
         if (vecs[i].chk_rd) begin
            check({nm, "_rdata"}, rd, vecs[i].rd);
            check({nm, "_rchk"}, rc, INTEG ? ref_enc(vecs[i].rd) : 7'd0);
         end
         check({nm, "_errcnt"}, errcnt0, exp_err);
      end

      // Back-to-back write then read of the same word
      hsel = 1; htrans = 2'b10; hwrite = 1; hsize = 3'b010; haddr = 32'h30;
      hparity = ref_par(32'h30, 1'b1, 3'b010, 2'b10);
      tick();
      hwrite = 0; hparity = ref_par(32'h30, 1'b0, 3'b010, 2'b10);
      hwdata = 32'h0BADC0DE; hwchk = ref_enc(32'h0BADC0DE);
      @(negedge clk);
      check("raw_wr_ready", rdy0, 1);
      check("raw_wr_resp", resp0, 0);
      tick();
      hsel = 0; htrans = 2'b00; hparity = '0;
      @(negedge clk);
      check("raw_rd_ready", rdy0, 1);
      check("raw_rdata", rdata0, 32'h0BADC0DE);
      tick();

      // Wait-state instance
      repeat (12) tick();
      xfer(1, 1, 3'b010, 32'h40, 32'h55AA55AA, 0, 0, lows, rl, re, rd, rc);
      check("ws_wr_lows", lows, 3);
      check("ws_wr_resp", re, 0);
      xfer(1, 0, 3'b010, 32'h40, 32'h0, 0, 0, lows, rl, re, rd, rc);
      check("ws_rd_lows", lows, 3);
      check("ws_rd_resp", re, 0);
      check("ws_rdata", rd, 32'h55AA55AA);
      check("ws_rchk", rc, INTEG ? ref_enc(32'h55AA55AA) : 7'd0);
      xfer(1, 0, 3'b010, 32'h2, 32'h0, 0, 0, lows, rl, re, rd, rc);
      check("ws_misalign_lows", lows, 1);
      check("ws_misalign_resp_low", rl, 1);
      check("ws_misalign_resp", re, 1);

      // Reset during a wait cycle of a write
      xfer(1, 1, 3'b010, 32'h44, 32'h13579BDF, 0, 0, lows, rl, re, rd, rc);
      hsel = 1; htrans = 2'b10; hwrite = 1; hsize = 3'b010; haddr = 32'h44;
      hparity = ref_par(32'h44, 1'b1, 3'b010, 2'b10);
      tick();
      hsel = 0; htrans = 2'b00; hwrite = 0; haddr = '0; hparity = '0;
      hwdata = 32'h2468ACE0; hwchk = ref_enc(32'h2468ACE0);
      @(negedge clk);
      check("mid_wait_ready", rdy3, 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready3", rdy3, 1);
      check("mid_rst_resp3", resp3, 0);
      check("mid_rst_rdata3", rdata3, 0);
      check("mid_rst_rchk3", rchk3, 0);
      check("mid_rst_errcnt3", errcnt3, 0);
      check("mid_rst_errcnt0", errcnt0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      xfer(1, 0, 3'b010, 32'h44, 32'h0, 0, 0, lows, rl, re, rd, rc);
      check("post_rst_rdata", rd, 32'h13579BDF);
      check("post_rst_lows", lows, 3);

      // Error counter saturation on the 2-bit counter
      for (int i = 1; i <= 4; i++) begin
         xfer(1, 0, 3'b010, 32'h2, 32'h0, 0, 0, lows, rl, re, rd, rc);
         check($sformatf("sat_errcnt_%0d", i), errcnt3, (i > 3) ? 3 : i);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ahb_protected_sram.md
Name: ahb_protected_sram

Overview:
AHB-Lite subordinate, single-ported word SRAM, serving the instruction or data port of the lockstepped Hardisc pair.
- Checks the custom address-phase parity (s_hparity) and write-data checksum (s_hwchecksum) that the cores generate.
- Returns read data with its stored checksum (s_hrchecksum).
- Any integrity, range or alignment violation is signalled with the standard two-cycle AHB ERROR response.

Parameters:
MEM_ADDR_W, 10, word-address width; memory holds 2^MEM_ADDR_W 32-bit words plus a 7-bit checksum per word.
WAIT_STATES, 0, extra data-phase cycles (0..7) inserted with s_hready_o=0 before every OKAY completion.
ERRCNT_W, 8, width of the saturating error counter.

Ports:
s_clk_i  in  1  clock
s_resetn_i  in  1  asynchronous active-low reset
s_hsel_i  in  1  subordinate select
s_haddr_i  in  32  byte address
s_htrans_i  in  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
s_hwrite_i  in  1  write indicator
s_hsize_i  in  3  transfer size (000 byte, 001 half, 010 word)
s_hparity_i  in  6  address-phase parity
s_hwdata_i  in  32  write data, valid in data phase
s_hwchecksum_i  in  7  (39,32) SEC-DED checksum of s_hwdata_i
s_hready_i  in  1  bus-level HREADY
s_hrdata_o  out  32  read data
s_hrchecksum_o  out  7  stored checksum of s_hrdata_o
s_hready_o  out  1  transfer done / subordinate ready
s_hresp_o  out  1  0 OKAY, 1 ERROR
s_errcnt_o  out  ERRCNT_W  saturating count of ERROR responses

Behaviour:
- Reset values:
  - s_hready_o=1, s_hresp_o=0, s_hrdata_o=0, s_hrchecksum_o=0, s_errcnt_o=0.
  - FSM in IDLE. Memory contents are not reset.
- Address-phase acceptance: s_hsel_i & s_htrans_i[1] & s_hready_i.
  - IDLE/BUSY transfers, or cycles with s_hsel_i=0, get a zero-wait OKAY.
- Accepted address, control and parity are registered for the data phase.
- Parity definition:
  - hparity[k] = ^haddr[8k+7:8k] for k=0..3.
  - hparity[4] = ^{hwrite,hsize}.
  - hparity[5] = ^htrans.
  - Checked at acceptance.
- Address-phase error is flagged when any of these hold:
  - parity mismatch;
  - haddr[31:MEM_ADDR_W+2] != 0;
  - s_hsize_i > 010;
  - misalignment (half with haddr[0]=1, word with haddr[1:0]!=0).
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: s_hready_o=1. On acceptance:
    - flagged error -> ERR1;
    - else WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1;
    - else the data phase completes this next cycle in IDLE.
  - WAIT: s_hready_o=0, s_hresp_o=0. Counter decrements; at 0 the data phase completes in the following cycle with s_hready_o=1.
  - ERR1: s_hready_o=0, s_hresp_o=1 -> ERR2.
  - ERR2: s_hready_o=1, s_hresp_o=1 -> IDLE. A new transfer presented during ERR2 is accepted normally.
- Write data phase (completing cycle):
  - Decode s_hwdata_i/s_hwchecksum_i with the p_hardisc (39,32) SEC-DED functions.
  - Any non-zero syndrome: no memory update; response becomes ERROR, driven as ERR1 in that cycle then ERR2. An error-free completion drives OKAY with s_hready_o=1 that cycle.
  - Sub-word writes merge the selected byte lanes into the stored word, then recompute and store the checksum of the merged word.
- Read data phase: s_hrdata_o/s_hrchecksum_o are driven from the array at the registered address in the completing cycle. They are held otherwise.
- Read-after-write to the same word in back-to-back transfers returns the newly written data: the write commits at the completing clock edge, before the read data phase.
- s_errcnt_o increments once per ERROR response (on entering ERR2) and saturates at all-ones.
- Reset mid-transfer: immediate return to IDLE with reset output values. No partial write is committed.

Optional Feature:
Macro: AHB_RESP_INTEGRITY_EN.
- Defined: parity and write-checksum checks are active as above; s_hrchecksum_o carries the stored checksum.
- Undefined:
  - parity and write-checksum are ignored; only range, size and alignment errors produce ERROR;
  - the stored checksum is still computed from the merged data;
  - s_hrchecksum_o is driven 0.

Test Plan:
1. WAIT_STATES=0, word write 0xDEADBEEF at 0x10 with correct parity/checksum, then read 0x10 -> OKAY, s_hready_o never low; read returns 0xDEADBEEF with its correct checksum.
2. Byte write 0xA5 to 0x11 over word 0x00000000 -> read returns 0x0000A500; checksum equals the SEC-DED encode of 0x0000A500.
3. Write to 0x10 with s_hparity_i[0] flipped -> s_hready_o/s_hresp_o = 0/1 then 1/1; word at 0x10 unchanged; s_errcnt_o=1.
4. Write with one s_hwchecksum_i bit flipped -> ERROR, memory unchanged; with macro undefined -> OKAY, data written.
5. WAIT_STATES=3, word read -> exactly 3 cycles with s_hready_o=0, then data and OKAY; misaligned word read at 0x2 -> ERROR.
6. Reset asserted during a WAIT cycle of a write -> outputs at reset values, FSM IDLE; subsequent read of that address returns the pre-write value.
